arith_sched: RTL and testbench

ARITH_SCHED -- requirements
Module: arith_sched

---
 rtl/arith_pkg.sv | 28 ++
 rtl/arith_seq_mult.sv | 71 +++++++
 rtl/arith_sched.sv | 152 +++++++++++++++
 tb/tb_arith_sched.sv | 318 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/arith_pkg.sv
// arith_pkg
// Shared definitions for the arithmetic scheduler:
//   state_t   - scheduler FSM states (IDLE, ADD, MUL, DONE)
//   OP_ADD    - op code for addition (0)
//   OP_MUL    - op code for multiplication (1)
//   calc_opw  - operand width, max(size_adder, size_mult)
//   calc_rw   - result width, max(size_adder+1, 2*size_mult)
package arith_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADD  = 2'd1,
    MUL  = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_MUL = 1'b1;

  function automatic int calc_opw(input int sa, input int sm);
    return (sa > sm) ? sa : sm;
  endfunction

  function automatic int calc_rw(input int sa, input int sm);
    return ((sa + 1) > (2 * sm)) ? (sa + 1) : (2 * sm);
  endfunction

endpackage

// File: rtl/arith_seq_mult.sv
// arith_seq_mult
// Iterative shift-add multiplier. Operands are loaded on the cycle start is
// high; the product is accumulated over exactly size_mult following cycles,
// one multiplier bit per cycle. done pulses for one cycle once the final
// partial product has been added, and product holds until the next start.
// Ports:
//   clk      in   clock, rising edge
//   rst_n    in   asynchronous active-low reset
//   start    in   load a/b and begin a multiplication
//   a, b     in   size_mult-bit unsigned operands
//   done     out  one-cycle pulse, product valid from this cycle on
//   product  out  2*size_mult-bit unsigned product
module arith_seq_mult
  import arith_pkg::*;
#(
  parameter int size_mult = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic [size_mult-1:0]     a,
  input  logic [size_mult-1:0]     b,
  output logic                     done,
  output logic [2*size_mult-1:0]   product
);

  localparam int CW = $clog2(size_mult + 1);

  logic [2*size_mult-1:0] mcand_reg;
  logic [2*size_mult-1:0] acc_reg;
  logic [size_mult-1:0]   mplier_reg;
  logic [CW-1:0]          count_reg;
  logic                   busy_reg;
  logic                   done_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcand_reg  <= '0;
      acc_reg    <= '0;
      mplier_reg <= '0;
      count_reg  <= '0;
      busy_reg   <= 1'b0;
      done_reg   <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      if (start) begin
        mcand_reg  <= {{size_mult{1'b0}}, a};
        mplier_reg <= b;
        acc_reg    <= '0;
        count_reg  <= CW'(size_mult);
        busy_reg   <= 1'b1;
      end else if (busy_reg) begin
        // Add the shifted multiplicand for each set multiplier bit, LSB first.
        if (mplier_reg[0]) begin
          acc_reg <= acc_reg + mcand_reg;
        end
        mcand_reg  <= mcand_reg << 1;
        mplier_reg <= mplier_reg >> 1;
        count_reg  <= count_reg - CW'(1);
        if (count_reg == CW'(1)) begin
          busy_reg <= 1'b0;
          done_reg <= 1'b1;
        end
      end
    end
  end

  assign done    = done_reg;
  assign product = acc_reg;

endmodule

// File: rtl/arith_sched.sv
// arith_sched
// Two-requester arithmetic scheduler. One operation (add or multiply) is in
// flight at a time. Requesters are arbitrated round-robin while IDLE; the
// accepted operation's operands are captured so later operand changes have
// no effect. Adds complete in one cycle; multiplies use the iterative
// arith_seq_mult. The result is held in DONE until the consumer accepts it.
// Ports:
//   clk, rst_n            clock and asynchronous active-low reset
//   r0_valid / r1_valid   requester has an operation pending
//   r0_ready / r1_ready   operation accepted (only in IDLE, one at a time)
//   r0_op / r1_op         0 = add, 1 = multiply
//   r0_x,r0_y / r1_x,r1_y operands (OPW bits)
//   rsp_valid / rsp_ready result handshake
//   rsp_id, rsp_op        owner and type of the result
//   rsp_data              result, zero-extended to RW bits
module arith_sched
  import arith_pkg::*;
#(
  parameter  int size_adder = 4,
  parameter  int size_mult  = 4,
  localparam int OPW        = calc_opw(size_adder, size_mult),
  localparam int RW         = calc_rw(size_adder, size_mult)
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           r0_valid,
  output logic           r0_ready,
  input  logic           r0_op,
  input  logic [OPW-1:0] r0_x,
  input  logic [OPW-1:0] r0_y,
  input  logic           r1_valid,
  output logic           r1_ready,
  input  logic           r1_op,
  input  logic [OPW-1:0] r1_x,
  input  logic [OPW-1:0] r1_y,
  output logic           rsp_valid,
  input  logic           rsp_ready,
  output logic           rsp_id,
  output logic           rsp_op,
  output logic [RW-1:0]  rsp_data
);

  state_t                state_reg;
  logic                  last_grant_reg;  // 1 when r1 was served last
  logic                  op_reg;
  logic                  id_reg;
  logic [size_adder-1:0] ax_reg;
  logic [size_adder-1:0] ay_reg;
  logic                  rsp_valid_reg;
  logic                  rsp_id_reg;
  logic                  rsp_op_reg;
  logic [RW-1:0]         rsp_data_reg;

  logic                  grant1;
  logic                  handshake;
  logic                  sel_op;
  logic [OPW-1:0]        sel_x;
  logic [OPW-1:0]        sel_y;

  logic                  mult_start;
  logic                  mult_done;
  logic [2*size_mult-1:0] mult_product;

  // Arbitration: r1 wins when it is the only one asking, or when both ask
  // and r0 was served last. The reset value of last_grant_reg makes r0 win
  // the first contested grant.
  always_comb begin
    grant1    = r1_valid && (!r0_valid || !last_grant_reg);
    r0_ready  = (state_reg == IDLE) && r0_valid && !grant1;
    r1_ready  = (state_reg == IDLE) && grant1;
    handshake = r0_ready || r1_ready;
    sel_op    = grant1 ? r1_op : r0_op;
    sel_x     = grant1 ? r1_x  : r0_x;
    sel_y     = grant1 ? r1_y  : r0_y;
  end

  // The multiplier loads straight from the accepted requester on the
  // handshake edge, so its size_mult iterations start the very next cycle.
  assign mult_start = handshake && (sel_op == OP_MUL);

  arith_seq_mult #(
    .size_mult (size_mult)
  ) u_mult (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (mult_start),
    .a       (sel_x[size_mult-1:0]),
    .b       (sel_y[size_mult-1:0]),
    .done    (mult_done),
    .product (mult_product)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg      <= IDLE;
      last_grant_reg <= 1'b1;
      op_reg         <= OP_ADD;
      id_reg         <= 1'b0;
      ax_reg         <= '0;
      ay_reg         <= '0;
      rsp_valid_reg  <= 1'b0;
      rsp_id_reg     <= 1'b0;
      rsp_op_reg     <= OP_ADD;
      rsp_data_reg   <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (handshake) begin
            op_reg         <= sel_op;
            id_reg         <= grant1;
            ax_reg         <= sel_x[size_adder-1:0];
            ay_reg         <= sel_y[size_adder-1:0];
            last_grant_reg <= grant1;
            state_reg      <= (sel_op == OP_MUL) ? MUL : ADD;
          end
        end
        ADD: begin
          // Full size_adder+1-bit sum, zero-extended to RW.
          rsp_data_reg  <= RW'(ax_reg) + RW'(ay_reg);
          rsp_id_reg    <= id_reg;
          rsp_op_reg    <= op_reg;
          rsp_valid_reg <= 1'b1;
          state_reg     <= DONE;
        end
        MUL: begin
          if (mult_done) begin
            rsp_data_reg  <= RW'(mult_product);
            rsp_id_reg    <= id_reg;
            rsp_op_reg    <= op_reg;
            rsp_valid_reg <= 1'b1;
            state_reg     <= DONE;
          end
        end
        DONE: begin
          if (rsp_ready) begin
            rsp_valid_reg <= 1'b0;
            state_reg     <= IDLE;
          end
        end
        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

  assign rsp_valid = rsp_valid_reg;
  assign rsp_id    = rsp_id_reg;
  assign rsp_op    = rsp_op_reg;
  assign rsp_data  = rsp_data_reg;

endmodule

// File: tb/tb_arith_sched.sv
// tb_arith_sched
// Self-checking bench for arith_sched with default parameters. Expected
// results come from plain arithmetic on the operands, expected latency from
// the operation type, and expected grants from a record of who was served
// last.
module tb_arith_sched;

  localparam int SA  = 4;
  localparam int SM  = 4;
  localparam int OPW = 4;
  localparam int RW  = 8;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           r0_valid = 1'b0, r1_valid = 1'b0;
  logic           r0_ready, r1_ready;
  logic           r0_op = 1'b0, r1_op = 1'b0;
  logic [OPW-1:0] r0_x = '0, r0_y = '0, r1_x = '0, r1_y = '0;
  logic           rsp_valid;
  logic           rsp_ready = 1'b1;
  logic           rsp_id;
  logic           rsp_op;
  logic [RW-1:0]  rsp_data;

  int errors = 0;
  int checks = 0;
  bit last_grant = 1'b1;  // model: requester served last (r0 favoured after reset)

  always #5 clk = ~clk;

  arith_sched #(
    .size_adder (SA),
    .size_mult  (SM)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .r0_valid  (r0_valid),
    .r0_ready  (r0_ready),
    .r0_op     (r0_op),
    .r0_x      (r0_x),
    .r0_y      (r0_y),
    .r1_valid  (r1_valid),
    .r1_ready  (r1_ready),
    .r1_op     (r1_op),
    .r1_x      (r1_x),
    .r1_y      (r1_y),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_op    (rsp_op),
    .rsp_data  (rsp_data)
  );

  function automatic int model_result(input bit op, input int x, input int y);
    if (op) return (x % (1 << SM)) * (y % (1 << SM));
    return (x % (1 << SA)) + (y % (1 << SA));
  endfunction

  function automatic int model_latency(input bit op);
    return op ? SM + 2 : 2;
  endfunction

  task automatic set_req(input bit id, input bit v, input bit op,
                         input logic [OPW-1:0] x, input logic [OPW-1:0] y);
    if (id) begin
      r1_valid = v; r1_op = op; r1_x = x; r1_y = y;
    end else begin
      r0_valid = v; r0_op = op; r0_x = x; r0_y = y;
    end
  endtask

  // Present one request, wait for its grant, then wait for rsp_valid.
  // Returns at the falling edge where rsp_valid is first seen; lat counts
  // cycles from the handshake cycle to that one.
  task automatic run_txn(input bit id, input bit op, input logic [OPW-1:0] x,
                         input logic [OPW-1:0] y, input bit scramble,
                         output int lat, output bit timeout);
    int k;
    timeout = 1'b0;
    lat = 0;
    @(posedge clk); #1;
    set_req(id, 1'b1, op, x, y);
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!(id ? r1_ready : r0_ready) && k < 50);
    if (!(id ? r1_ready : r0_ready)) begin
      timeout = 1'b1;
      set_req(id, 1'b0, op, x, y);
      return;
    end
    @(posedge clk); #1;
    last_grant = id;
    if (scramble) set_req(id, 1'b0, ~op, ~x, ~y);
    else          set_req(id, 1'b0, op, x, y);
    k = 1;
    @(negedge clk);
    while (!rsp_valid && k < 50) begin
      @(negedge clk);
      k++;
    end
    if (!rsp_valid) timeout = 1'b1;
    lat = k;
  endtask

  task automatic accept_rsp();
    rsp_ready = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid: got %0b expected 0", rsp_valid); end
    checks++; if (rsp_data !== 8'd0) begin errors++; $display("FAIL reset_rsp_data: got %0d expected 0", rsp_data); end
    checks++; if (rsp_id !== 1'b0) begin errors++; $display("FAIL reset_rsp_id: got %0b expected 0", rsp_id); end
    checks++; if (rsp_op !== 1'b0) begin errors++; $display("FAIL reset_rsp_op: got %0b expected 0", rsp_op); end
    checks++; if (r0_ready !== 1'b0 || r1_ready !== 1'b0) begin errors++; $display("FAIL reset_ready_idle: got r0=%0b r1=%0b expected 0 0", r0_ready, r1_ready); end
    // Both asking while held in reset: IDLE rules with r0 favoured.
    r0_valid = 1'b1; r1_valid = 1'b1;
    #1;
    checks++; if (r0_ready !== 1'b1 || r1_ready !== 1'b0) begin errors++; $display("FAIL reset_priority: got r0=%0b r1=%0b expected 1 0", r0_ready, r1_ready); end
    r0_valid = 1'b0; r1_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    $display("txn reset: released");
  endtask

  task automatic test_add_basic();
    int lat; bit to;
    rsp_ready = 1'b1;
    run_txn(1'b0, 1'b0, 4'd9, 4'd8, 1'b0, lat, to);
    checks++; if (to) begin errors++; $display("FAIL add_basic_timeout: got timeout expected response"); end
    checks++; if (lat !== 2) begin errors++; $display("FAIL add_basic_latency: got %0d expected 2", lat); end
    checks++; if (rsp_data !== 8'd17) begin errors++; $display("FAIL add_basic_data: got %0d expected 17", rsp_data); end
    checks++; if (rsp_id !== 1'b0 || rsp_op !== 1'b0) begin errors++; $display("FAIL add_basic_idop: got id=%0b op=%0b expected 0 0", rsp_id, rsp_op); end
    $display("txn add r0 9+8: data=%0d lat=%0d", rsp_data, lat);
    accept_rsp();
  endtask

  task automatic test_mul_basic();
    int lat; bit to;
    rsp_ready = 1'b1;
    run_txn(1'b1, 1'b1, 4'd15, 4'd15, 1'b0, lat, to);
    checks++; if (to) begin errors++; $display("FAIL mul_basic_timeout: got timeout expected response"); end
    checks++; if (lat !== model_latency(1'b1)) begin errors++; $display("FAIL mul_basic_latency: got %0d expected %0d", lat, model_latency(1'b1)); end
    checks++; if (rsp_data !== 8'd225) begin errors++; $display("FAIL mul_basic_data: got %0d expected 225", rsp_data); end
    checks++; if (rsp_id !== 1'b1 || rsp_op !== 1'b1) begin errors++; $display("FAIL mul_basic_idop: got id=%0b op=%0b expected 1 1", rsp_id, rsp_op); end
    $display("txn mul r1 15*15: data=%0d lat=%0d", rsp_data, lat);
    accept_rsp();
  endtask

  task automatic test_back_to_back();
    int exp_q[$];
    bit id_q[$];
    bit ops[2];
    logic [OPW-1:0] xs[2], ys[2];
    int grants = 0;
    int cyc = 0;
    bit got;
    int e; bit eid;
    rsp_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      ops[i] = 1'($urandom_range(0, 1));
      xs[i] = 4'($urandom_range(0, 15));
      ys[i] = 4'($urandom_range(0, 15));
      set_req(i[0], 1'b1, ops[i], xs[i], ys[i]);
    end
    while ((grants < 4 || exp_q.size() > 0) && cyc < 300) begin
      @(negedge clk);
      cyc++;
      checks++; if (r0_ready && r1_ready) begin errors++; $display("FAIL rr_both_ready: got r0=1 r1=1 expected at most one"); end
      if (r0_ready || r1_ready) begin
        got = r1_ready;
        checks++; if (got !== ~last_grant) begin errors++; $display("FAIL rr_grant_order: got r%0d expected r%0d", got, ~last_grant); end
        exp_q.push_back(model_result(ops[got], xs[got], ys[got]));
        id_q.push_back(got);
        last_grant = got;
        grants++;
        $display("txn rr grant %0d: r%0d op=%0d x=%0d y=%0d", grants, got, ops[got], xs[got], ys[got]);
        @(posedge clk); #1;
        if (grants >= 4) begin
          set_req(1'b0, 1'b0, 1'b0, '0, '0);
          set_req(1'b1, 1'b0, 1'b0, '0, '0);
        end else begin
          ops[got] = 1'($urandom_range(0, 1));
          xs[got] = 4'($urandom_range(0, 15));
          ys[got] = 4'($urandom_range(0, 15));
          set_req(got, 1'b1, ops[got], xs[got], ys[got]);
        end
      end else if (rsp_valid && exp_q.size() > 0) begin
        e = exp_q.pop_front();
        eid = id_q.pop_front();
        checks++; if (rsp_data !== RW'(e) || rsp_id !== eid) begin errors++; $display("FAIL rr_result: got data=%0d id=%0b expected data=%0d id=%0b", rsp_data, rsp_id, e, eid); end
      end
    end
    checks++; if (cyc >= 300) begin errors++; $display("FAIL rr_timeout: got %0d grants expected 4", grants); end
    set_req(1'b0, 1'b0, 1'b0, '0, '0);
    set_req(1'b1, 1'b0, 1'b0, '0, '0);
    @(posedge clk); #1;
  endtask

  task automatic test_backpressure();
    int lat; bit to;
    int exp;
    exp = model_result(1'b1, 7, 6);
    rsp_ready = 1'b0;
    run_txn(1'b0, 1'b1, 4'd7, 4'd6, 1'b0, lat, to);
    checks++; if (to || lat !== model_latency(1'b1)) begin errors++; $display("FAIL bp_latency: got %0d timeout=%0b expected %0d", lat, to, model_latency(1'b1)); end
    set_req(1'b1, 1'b1, 1'b0, 4'd1, 4'd2);
    for (int i = 0; i < 5; i++) begin
      checks++; if (rsp_valid !== 1'b1 || rsp_data !== RW'(exp)) begin errors++; $display("FAIL bp_hold: got valid=%0b data=%0d expected 1 %0d", rsp_valid, rsp_data, exp); end
      checks++; if (r0_ready !== 1'b0 || r1_ready !== 1'b0) begin errors++; $display("FAIL bp_no_grant: got r0=%0b r1=%0b expected 0 0", r0_ready, r1_ready); end
      @(negedge clk);
    end
    $display("txn mul r0 7*6 held: data=%0d", rsp_data);
    accept_rsp();
    set_req(1'b1, 1'b0, 1'b0, '0, '0);
    @(negedge clk);
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL bp_release: got valid=%0b expected 0", rsp_valid); end
  endtask

  task automatic test_reset_mid();
    int k;
    int seen;
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    set_req(1'b0, 1'b1, 1'b1, 4'd5, 4'd3);
    k = 0;
    do begin @(negedge clk); k++; end while (!r0_ready && k < 50);
    checks++; if (!r0_ready) begin errors++; $display("FAIL rmid_grant: got no grant expected r0"); end
    @(posedge clk); #1;
    set_req(1'b0, 1'b0, 1'b0, '0, '0);
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    checks++; if (rsp_valid !== 1'b0 || rsp_data !== 8'd0 || rsp_id !== 1'b0 || rsp_op !== 1'b0) begin errors++; $display("FAIL rmid_outputs: got valid=%0b data=%0d id=%0b op=%0b expected 0 0 0 0", rsp_valid, rsp_data, rsp_id, rsp_op); end
    @(negedge clk);
    rst_n = 1'b1;
    last_grant = 1'b1;
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (rsp_valid) seen++;
    end
    checks++; if (seen !== 0) begin errors++; $display("FAIL rmid_no_response: got %0d valid cycles expected 0", seen); end
    @(posedge clk); #1;
    set_req(1'b0, 1'b1, 1'b0, 4'd3, 4'd4);
    set_req(1'b1, 1'b1, 1'b0, 4'd1, 4'd1);
    @(negedge clk);
    checks++; if (r0_ready !== 1'b1 || r1_ready !== 1'b0) begin errors++; $display("FAIL rmid_priority: got r0=%0b r1=%0b expected 1 0", r0_ready, r1_ready); end
    @(posedge clk); #1;
    last_grant = 1'b0;
    set_req(1'b0, 1'b0, 1'b0, '0, '0);
    set_req(1'b1, 1'b0, 1'b0, '0, '0);
    k = 0;
    do begin @(negedge clk); k++; end while (!rsp_valid && k < 50);
    checks++; if (rsp_valid !== 1'b1 || rsp_data !== 8'd7 || rsp_id !== 1'b0) begin errors++; $display("FAIL rmid_add: got valid=%0b data=%0d id=%0b expected 1 7 0", rsp_valid, rsp_data, rsp_id); end
    $display("txn add r0 3+4 after reset: data=%0d", rsp_data);
    accept_rsp();
  endtask

  task automatic test_operand_change();
    int lat; bit to;
    rsp_ready = 1'b1;
    run_txn(1'b0, 1'b0, 4'd5, 4'd5, 1'b1, lat, to);
    checks++; if (to || rsp_data !== 8'd10) begin errors++; $display("FAIL opchg_data: got %0d timeout=%0b expected 10", rsp_data, to); end
    $display("txn add r0 5+5 operands changed: data=%0d", rsp_data);
    accept_rsp();
  endtask

  task automatic test_random();
    int lat; bit to;
    bit id, op;
    logic [OPW-1:0] x, y;
    int hold, exp;
    for (int n = 0; n < 20; n++) begin
      id = 1'($urandom_range(0, 1));
      op = 1'($urandom_range(0, 1));
      x = 4'($urandom_range(0, 15));
      y = 4'($urandom_range(0, 15));
      hold = $urandom_range(0, 3);
      exp = model_result(op, x, y);
      rsp_ready = (hold == 0);
      run_txn(id, op, x, y, 1'($urandom_range(0, 1)), lat, to);
      checks++; if (to || lat !== model_latency(op)) begin errors++; $display("FAIL rand_latency: got %0d timeout=%0b expected %0d", lat, to, model_latency(op)); end
      checks++; if (rsp_data !== RW'(exp) || rsp_id !== id || rsp_op !== op) begin errors++; $display("FAIL rand_result: got data=%0d id=%0b op=%0b expected %0d %0b %0b", rsp_data, rsp_id, rsp_op, exp, id, op); end
      for (int h = 0; h < hold; h++) begin
        @(negedge clk);
        checks++; if (rsp_valid !== 1'b1 || rsp_data !== RW'(exp)) begin errors++; $display("FAIL rand_hold: got valid=%0b data=%0d expected 1 %0d", rsp_valid, rsp_data, exp); end
      end
      $display("txn rand %0d: r%0d op=%0d x=%0d y=%0d data=%0d lat=%0d hold=%0d", n, id, op, x, y, rsp_data, lat, hold);
      accept_rsp();
    end
  endtask

  initial begin
    test_reset();
    test_add_basic();
    test_mul_basic();
    test_back_to_back();
    test_backpressure();
    test_reset_mid();
    test_operand_change();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got simulation time limit expected completion");
    $fatal(1, "watchdog");
  end

endmodule
